// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
//   fetch_state_e : fetch FSM states (IDLE, REQ, WAIT, DROP)
//   fetch_entry_t : one prefetch-queue entry, {pc, ins}
//   IF_ADDR_W     : default PC/address width
//   IF_RESET_PC   : default boot entry point
package if_pkg;

  localparam int                   IF_ADDR_W   = 32;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = 32'd128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing in flight, waiting for queue space
    REQ  = 2'd1,  // mem_req asserted, waiting for mem_gnt
    WAIT = 2'd2,  // granted, waiting for mem_rvalid
    DROP = 2'd3   // granted, response belongs to a stale PC and is discarded
  } fetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [31:0]          ins;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Bus bundle for the prefetch unit: instruction-memory handshake,
// redirect input from the PC unit and the valid/ready link to decode.
//   master : the prefetch unit
//   slave  : its environment (memory, PC unit, decode)
interface if_prefetch_if #(
  parameter int ADDR_W = if_pkg::IF_ADDR_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ins;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pcp4;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  redirect, redirect_pc,
    output out_valid, out_ins, out_pc, out_pcp4,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output redirect, redirect_pc,
    input  out_valid, out_ins, out_pc, out_pcp4,
    output out_ready
  );

endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush and a registered head output.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the queue; overrides push and pop
//   push, din  : write an entry (ignored when full)
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry; holds its last value while empty
//   count      : occupancy, 0..DEPTH
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign count      = wr_ptr - rd_ptr;
  assign do_push    = push && !flush && (count != (PTR_W+1)'(DEPTH));
  assign do_pop     = pop && !flush && (count != '0);
  assign wr_ptr_nxt = wr_ptr + (PTR_W+1)'(do_push);
  assign rd_ptr_nxt = rd_ptr + (PTR_W+1)'(do_pop);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // slots are valid, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  // Head register: preload the entry that will be at the head after this
  // edge. When that slot is the one being written now, take din directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (!flush && (rd_ptr_nxt != wr_ptr_nxt)) begin
      dout <= (rd_ptr_nxt == wr_ptr) ? din : mem[rd_ptr_nxt[PTR_W-1:0]];
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end feeding decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : if_prefetch_if.master
//     mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata : instruction memory
//     redirect/redirect_pc                         : branch/jump/INT entry
//     out_valid/out_ready/out_ins/out_pc/out_pcp4  : head of queue to decode
// At most one fetch is in flight; it reserves a queue slot so a returning
// response can always be pushed. A redirect flushes the queue and marks any
// in-flight response for discard.
module if_prefetch
  import if_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC
) (
  input logic           clk,
  input logic           rst_n,
  if_prefetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [CNT_W-1:0]  count, count_after;
  logic              push, pop, outstanding, has_room, room_after;
  fetch_entry_t      push_entry, head_entry;

  // A response is pushed only in WAIT; a simultaneous redirect discards it.
  assign push        = (state == WAIT) && bus.mem_rvalid && !bus.redirect;
  assign pop         = bus.out_valid && bus.out_ready && !bus.redirect;
  assign outstanding = (state == WAIT) || (state == DROP);
  assign has_room    = (CNT_W'(DEPTH) - count) > CNT_W'(outstanding);
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign room_after  = (count_after != CNT_W'(DEPTH));

  // fetch_pc already advanced on the grant, so the in-flight address is
  // fetch_pc - 4 whenever a response is being pushed.
  assign push_entry = {fetch_pc - ADDR_W'(4), bus.mem_rdata};

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no
    // latch is inferred.
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;

    case (state)
      IDLE: begin
        if (bus.redirect || has_room) state_nxt = REQ;
      end
      REQ: begin
        if (bus.mem_gnt) state_nxt = bus.redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt = (bus.redirect || room_after) ? REQ : IDLE;
        end else if (bus.redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (bus.mem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.redirect) begin
      fetch_pc_nxt = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    end else if ((state == REQ) && bus.mem_gnt) begin
      fetch_pc_nxt = fetch_pc + ADDR_W'(4);
    end
  end

  assign bus.mem_req   = (state == REQ);
  assign bus.mem_addr  = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_ins   = head_entry.ins;
  assign bus.out_pc    = head_entry.pc;
  assign bus.out_pcp4  = head_entry.pc + ADDR_W'(4);

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: memory responder with programmable
// grant enable and grant-to-rvalid latency, decode sink via out_ready.
module tb_if_prefetch;

  logic clk = 1'b0;
  logic rst_n;
  logic gnt_en;
  int   lat;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  if_prefetch_if #(.ADDR_W(32)) bus ();

  if_prefetch #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .RESET_PC (32'd128)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.mem_gnt = bus.mem_req & gnt_en;

  function automatic logic [31:0] ins_for(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  // Memory responder: acts just after each falling edge, once the main
  // sequence has set that cycle's inputs.
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_cnt == 1) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = ins_for(rsp_addr);
        rsp_cnt        = 0;
      end else begin
        bus.mem_rvalid = 1'b0;
        if (rsp_cnt > 1) rsp_cnt--;
      end
      if (bus.mem_req && bus.mem_gnt) begin
        rsp_cnt  = lat;
        rsp_addr = bus.mem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b1;
    gnt_en          = 1'b1;
    lat             = 1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst mem_req",   32'(bus.mem_req),   32'd0);
    check("rst mem_addr",  bus.mem_addr,       32'd128);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_ins",   bus.out_ins,        32'd0);
    check("rst out_pc",    bus.out_pc,         32'd0);

    // Streaming with single-cycle memory and an always-ready decoder.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t1 first req",   32'(bus.mem_req),   32'd1);
    check("t1 first addr",  bus.mem_addr,       32'd128);
    check("t1 no valid",    32'(bus.out_valid), 32'd0);
    step();
    check("t1 wait no req", 32'(bus.mem_req),   32'd0);
    check("t1 wait no vld", 32'(bus.out_valid), 32'd0);
    step();
    check("t1 valid 128",   32'(bus.out_valid), 32'd1);
    check("t1 pc 128",      bus.out_pc,         32'd128);
    check("t1 ins 128",     bus.out_ins,        32'hC0DE_0080);
    check("t1 pcp4 132",    bus.out_pcp4,       32'd132);
    check("t1 addr 132",    bus.mem_addr,       32'd132);
    check("t1 req 132",     32'(bus.mem_req),   32'd1);
    step();
    check("t1 empty",       32'(bus.out_valid), 32'd0);
    check("t1 pc hold",     bus.out_pc,         32'd128);
    step();
    check("t1 pc 132",      bus.out_pc,         32'd132);
    check("t1 addr 136",    bus.mem_addr,       32'd136);
    step();
    step();
    check("t1 pc 136",      bus.out_pc,         32'd136);
    check("t1 ins 136",     bus.out_ins,        32'hC0DE_0088);
    check("t1 addr 140",    bus.mem_addr,       32'd140);

    // Stalled decoder: the queue fills after four fetches, then resumes.
    bus.out_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2 fill req",  32'(bus.mem_req), 32'd1);
      check("t2 fill addr", bus.mem_addr,     32'(128 + 4 * i));
      step();
    end
    step();
    check("t2 full no req",  32'(bus.mem_req),   32'd0);
    check("t2 full valid",   32'(bus.out_valid), 32'd1);
    check("t2 full head",    bus.out_pc,         32'd128);
    step();
    check("t2 full no req2", 32'(bus.mem_req),   32'd0);
    bus.out_ready = 1'b1;
    step();
    check("t2 pop no req",   32'(bus.mem_req),   32'd0);
    check("t2 head 132",     bus.out_pc,         32'd132);
    step();
    check("t2 resume req",   32'(bus.mem_req),   32'd1);
    check("t2 resume 144",   bus.mem_addr,       32'd144);
    check("t2 head 136",     bus.out_pc,         32'd136);
    step();
    check("t2 head 140",     bus.out_pc,         32'd140);
    step();
    check("t2 push+pop pc",  bus.out_pc,         32'd144);
    check("t2 push+pop ins", bus.out_ins,        32'hC0DE_0090);
    check("t2 push+pop vld", 32'(bus.out_valid), 32'd1);
    check("t2 addr 148",     bus.mem_addr,       32'd148);

    // Redirect while waiting on 136: queue flushed, response dropped.
    bus.out_ready = 1'b0;
    lat = 2;
    reset_dut();
    repeat (7) step();
    check("t3 req 136",      bus.mem_addr,       32'd136);
    step();
    check("t3 pre valid",    32'(bus.out_valid), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect = 1'b0;
    check("t3 flushed",      32'(bus.out_valid), 32'd0);
    check("t3 drop no req",  32'(bus.mem_req),   32'd0);
    check("t3 drop addr",    bus.mem_addr,       32'h0000_0200);
    step();
    check("t3 new req",      32'(bus.mem_req),   32'd1);
    check("t3 new addr",     bus.mem_addr,       32'h0000_0200);
    wait_valid("t3 valid timeout", 20);
    check("t3 first pc",     bus.out_pc,         32'h0000_0200);
    check("t3 first ins",    bus.out_ins,        32'hC0DE_0200);

    // Redirect arriving together with rvalid; low bits of the target cleared.
    bus.out_ready = 1'b1;
    lat = 1;
    reset_dut();
    step();
    check("t4 addr 128",     bus.mem_addr,       32'd128);
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    step();
    bus.redirect = 1'b0;
    check("t4 req",          32'(bus.mem_req),   32'd1);
    check("t4 aligned addr", bus.mem_addr,       32'h0000_0200);
    check("t4 discarded",    32'(bus.out_valid), 32'd0);
    wait_valid("t4 valid timeout", 20);
    check("t4 first pc",     bus.out_pc,         32'h0000_0200);

    // Grant stalled: address held, redirect retargets the pending request.
    gnt_en = 1'b0;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5 stall req",  32'(bus.mem_req), 32'd1);
      check("t5 stall addr", bus.mem_addr,     32'd128);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    step();
    bus.redirect = 1'b0;
    gnt_en       = 1'b1;
    check("t5 redir req",    32'(bus.mem_req),   32'd1);
    check("t5 redir addr",   bus.mem_addr,       32'h0000_0300);
    wait_valid("t5 valid timeout", 20);
    check("t5 first pc",     bus.out_pc,         32'h0000_0300);

    // Asynchronous reset in WAIT with three entries queued.
    bus.out_ready = 1'b0;
    reset_dut();
    repeat (8) step();
    check("t6 pre valid",    32'(bus.out_valid), 32'd1);
    check("t6 pre head",     bus.out_pc,         32'd128);
    rst_n = 1'b0;
    #1;
    check("t6 rst valid",    32'(bus.out_valid), 32'd0);
    check("t6 rst req",      32'(bus.mem_req),   32'd0);
    check("t6 rst pc",       bus.out_pc,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6 restart req",  32'(bus.mem_req),   32'd1);
    check("t6 restart addr", bus.mem_addr,       32'd128);

    // Redirects while in DROP: stay in DROP, last target wins.
    bus.out_ready = 1'b1;
    lat = 3;
    reset_dut();
    step();
    check("t7 addr 128",     bus.mem_addr,       32'd128);
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    step();
    bus.redirect_pc = 32'h0000_0500;
    check("t7 drop no req",  32'(bus.mem_req),   32'd0);
    check("t7 drop 400",     bus.mem_addr,       32'h0000_0400);
    step();
    bus.redirect = 1'b0;
    check("t7 still drop",   32'(bus.mem_req),   32'd0);
    check("t7 drop 500",     bus.mem_addr,       32'h0000_0500);
    step();
    check("t7 req 500",      32'(bus.mem_req),   32'd1);
    check("t7 addr 500",     bus.mem_addr,       32'h0000_0500);

    // Redirect from IDLE to the top word: PC and PC+4 wrap to zero.
    lat = 1;
    reset_dut();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    check("t8 req top",      32'(bus.mem_req),   32'd1);
    check("t8 addr top",     bus.mem_addr,       32'hFFFF_FFFC);
    step();
    step();
    check("t8 valid",        32'(bus.out_valid), 32'd1);
    check("t8 pc top",       bus.out_pc,         32'hFFFF_FFFC);
    check("t8 pcp4 wrap",    bus.out_pcp4,       32'd0);
    check("t8 addr wrap",    bus.mem_addr,       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
